// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM -> WB pipeline register with a load handshake to data memory.
// A three-state FSM (IDLE, WAIT, HOLD) requests the read word, aligns it on funct3 and
// MEM_addr, and captures the instruction into the WB registers exactly once.
// Optional feature macro: MEM_WB_RETIRE_CNT_EN adds a 64-bit retire_count output.
// Handshake: dmem_read is a level request that stays high until dmem_resp is seen. Upstream
// stages must hold the MEM inputs steady while mem_stall is high. stall_in holds the whole
// pipe; with a non-load in MEM it only produces a bubble.

package rv32i_types;
  typedef logic [4:0] rv32i_reg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    logic        load_regfile;
    rv32i_opcode opcode;
    logic [2:0]  funct3;
  } rv32i_control_word;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
endpackage

module mem_wb_stage
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MEM_valid,
  input  rv32i_control_word MEM_ctrlword,
  input  rv32i_reg          MEM_rd_num,
  input  logic [31:0]       MEM_alu_out,
  input  logic [31:0]       MEM_addr,
  input  logic              stall_in,
  input  logic              dmem_resp,
  input  logic [31:0]       dmem_rdata,
  output logic              dmem_read,
  output logic              mem_stall,
  output logic              WB_valid,
  output rv32i_control_word WB_ctrlword,
  output rv32i_reg          WB_rd_num,
  output logic [31:0]       WB_rd_data,
  output logic [1:0]        state_dbg
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  output logic [63:0]       retire_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] hold_q;
  logic [31:0] aligned;
  logic [31:0] wb_data;
  logic        is_load;
  logic        read_c, stall_c;
  logic        capture, latch_hold, use_hold;
  logic        unused_addr_hi;

  // Only the byte offset of the load address matters for alignment.
  assign unused_addr_hi = ^MEM_addr[31:2];

  assign is_load   = MEM_valid && (MEM_ctrlword.opcode == op_load);
  assign state_dbg = state_q;

  // Byte/halfword/word selection with sign or zero extension.
  function automatic logic [31:0] align_load(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_LB:   r = {{24{b[7]}}, b};
      F3_LBU:  r = {24'd0, b};
      F3_LH:   r = {{16{h[15]}}, h};
      F3_LHU:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign aligned = align_load(dmem_rdata, MEM_addr[1:0], MEM_ctrlword.funct3);
  assign wb_data = is_load ? (use_hold ? hold_q : aligned) : MEM_alu_out;

  // Reset forces the memory request and the upstream hold low immediately.
  assign dmem_read = rst_n & read_c;
  assign mem_stall = rst_n & stall_c;

  // Next-state and handshake decode.
  always_comb begin
    state_d    = state_q;
    read_c     = 1'b0;
    stall_c    = 1'b0;
    capture    = 1'b0;
    latch_hold = 1'b0;
    use_hold   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_load) begin
          read_c = 1'b1;
          if (dmem_resp) begin
            if (stall_in) begin
              state_d    = S_HOLD;
              latch_hold = 1'b1;
              stall_c    = 1'b1;
            end else begin
              capture = 1'b1;
            end
          end else begin
            state_d = S_WAIT;
            stall_c = 1'b1;
          end
        end else begin
          capture = !stall_in;
        end
      end
      S_WAIT: begin
        read_c = 1'b1;
        if (dmem_resp) begin
          if (stall_in) begin
            state_d    = S_HOLD;
            latch_hold = 1'b1;
            stall_c    = 1'b1;
          end else begin
            state_d = S_IDLE;
            capture = 1'b1;
          end
        end else begin
          stall_c = 1'b1;
        end
      end
      S_HOLD: begin
        if (stall_in) begin
          stall_c = 1'b1;
        end else begin
          state_d  = S_IDLE;
          capture  = 1'b1;
          use_hold = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Aligned load data parked while the pipe is held after the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          hold_q <= 32'd0;
    else if (latch_hold) hold_q <= aligned;
  end

  // WB registers: capture once, otherwise insert a bubble that cannot write the regfile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WB_valid    <= 1'b0;
      WB_ctrlword <= '0;
      WB_rd_num   <= '0;
      WB_rd_data  <= 32'd0;
    end else if (capture) begin
      WB_valid                 <= MEM_valid;
      WB_ctrlword              <= MEM_ctrlword;
      WB_ctrlword.load_regfile <= MEM_ctrlword.load_regfile && MEM_valid &&
                                  (MEM_rd_num != 5'd0);
      WB_rd_num                <= MEM_rd_num;
      WB_rd_data               <= wb_data;
    end else begin
      WB_valid                 <= 1'b0;
      WB_ctrlword.load_regfile <= 1'b0;
    end
  end

`ifdef MEM_WB_RETIRE_CNT_EN
  // Count every cycle a valid instruction sits in WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        retire_count <= 64'd0;
    else if (WB_valid) retire_count <= retire_count + 64'd1;
  end
`endif

endmodule
